product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream stage of the 16x16 DSP multiplier test design. It consumes the 32-bit unsigned products the multiplier emits on a valid/ready stream. It sums each group of COUNT consecutive products and emits one 32-bit total per group on a registered valid/ready output. It is the accumulate half of the MAC datapath under test and is fully backpressure-aware on both sides.

## Interface
- COUNT, default 4: products per group; legal range 1..256.
- clock  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears count, accumulator and output register.
- din_valid  input  1  upstream product present on din.
- din_ready  output  1  block accepts din this cycle.
- din  input  32  unsigned product from the multiplier stage.
- dout_valid  output  1  group total present on dout.
- dout_ready  input  1  downstream accepts dout this cycle.
- dout  output  32  group total; registered.

## Operation
- Beat accepted on din when din_valid && din_ready. Output beat taken when dout_valid && dout_ready.
- Internal accumulator acc is ACC_W = 32 + clog2(COUNT) bits wide (33 bits when COUNT=1); it cannot overflow internally. Beat counter cnt is clog2(COUNT)+1 bits.
- State machine, two states:
  - ACCUM is the reset state. din_ready = 1.
    - An accepted beat with cnt < COUNT-1 sets acc <= acc + din and increments cnt.
    - An accepted beat with cnt == COUNT-1 loads dout <= reduce(acc + din), sets dout_valid <= 1, clears acc and cnt, and moves to OUT.
    - Cycles with din_valid low hold all state. Gaps within a group are legal.
  - OUT: dout_valid = 1 and din_ready = dout_ready (combinational pass-through).
    - With dout_ready low: dout is held stable and no input is accepted.
    - With dout_ready high and no din beat: dout_valid <= 0, go to ACCUM.
    - With dout_ready high and a din beat in the same cycle: the beat is the first beat of the next group.
      - COUNT > 1: acc <= din, cnt <= 1, go to ACCUM.
      - COUNT == 1: dout <= reduce(din); stay in OUT.
- reduce() maps the ACC_W-bit sum to 32 bits; its behaviour is set by the macro in Configuration.
- Products are treated as unsigned. No signed mode.

## Timing
- Reset values: dout_valid = 0, dout = 32'h0, acc = 0, cnt = 0, state = ACCUM. din_ready reads 1 in the reset state.
  - Beats presented while reset is high are not accumulated.
  - Reset asserted mid-group discards the partial sum.
  - Reset asserted while in OUT drops the pending total.
- Latency: dout_valid rises the cycle after the last beat of the group is accepted.
- Throughput: with din_valid and dout_ready held high, one total is produced every COUNT cycles with no bubble.
- dout and dout_valid change only on clock edges. din_ready depends combinationally on the state register and dout_ready only.
- Once dout_valid rises, dout holds its value until the output beat is taken or reset is asserted.

## Configuration
- ACCUM_SAT_EN defined: reduce() saturates. Any sum > 32'hFFFFFFFF yields 32'hFFFFFFFF.
- ACCUM_SAT_EN undefined: reduce() truncates, giving the low 32 bits (modulo 2^32).
- ACC_W, the handshake and the timing are identical in both builds.

## Test plan
- COUNT=4, dout_ready=1, din 1,2,3,4 on consecutive cycles -> dout=10 with dout_valid high on the cycle after beat 4 for one cycle; a second group 10,20,30,40 follows with no bubble -> dout=100.
- COUNT=4, din_valid toggled 1,0,1,0,... with din=5 -> dout=20 after the 4th accepted beat; idle cycles do not change the result.
- COUNT=4, group 1,1,1,1 completes with dout_ready held low 5 cycles and din_valid=1 -> dout stays 4, dout_valid stays 1, din_ready stays 0, no beats consumed.
  - Then dout_ready=1 with din=7 in the same cycle -> total taken and 7 becomes beat 1 of the next group; beats 7,0,0,0 -> dout=7.
- COUNT=2, din 32'hFFFFFFFF twice -> dout=32'hFFFFFFFF with ACCUM_SAT_EN; dout=32'hFFFFFFFE without.
- COUNT=4, beats 9,9 then reset pulsed 1 cycle, then 5,5,5,5 -> dout=20; dout_valid=0 and dout=0 during and after reset until the group completes.
- COUNT=1, din_valid=1, dout_ready=1, din 3,4,5 -> dout 3,4,5 on consecutive cycles with dout_valid continuously high.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums each group of COUNT unsigned 32-bit products and emits one registered total per group.
// Optional macro ACCUM_SAT_EN: saturate totals above 32'hFFFFFFFF instead of keeping the low 32 bits.
module product_accumulator #(
  parameter int COUNT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout
);

  localparam int ACC_W = 32 + ((COUNT == 1) ? 1 : $clog2(COUNT));
  localparam int CNT_W = $clog2(COUNT) + 1;

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_OUT   = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_dout;
  logic             r_dout_valid;

  logic             w_din_ready;
  logic             w_in_fire;
  logic [ACC_W-1:0] w_din_ext;
  logic [ACC_W-1:0] w_sum;
  logic [31:0]      w_sum_red;

  // While a total is pending, input is only taken in the same cycle the total leaves.
  assign w_din_ready = (r_state == S_OUT) ? dout_ready : 1'b1;
  assign w_in_fire   = din_valid && w_din_ready;
  assign w_din_ext   = {{(ACC_W-32){1'b0}}, din};
  assign w_sum       = r_acc + w_din_ext;

`ifdef ACCUM_SAT_EN
  assign w_sum_red = (|w_sum[ACC_W-1:32]) ? 32'hFFFF_FFFF : w_sum[31:0];
`else
  assign w_sum_red = w_sum[31:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_dout       <= 32'h0;
      r_dout_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_in_fire) begin
            if (r_cnt == LAST_CNT) begin
              r_dout       <= w_sum_red;
              r_dout_valid <= 1'b1;
              r_acc        <= '0;
              r_cnt        <= '0;
              r_state      <= S_OUT;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (dout_ready) begin
            if (!din_valid) begin
              r_dout_valid <= 1'b0;
              r_state      <= S_ACCUM;
            end else if (COUNT == 1) begin
              // A one-beat group completes immediately, so the output stays occupied.
              r_dout <= din;
            end else begin
              r_acc        <= w_din_ext;
              r_cnt        <= CNT_W'(1);
              r_dout_valid <= 1'b0;
              r_state      <= S_ACCUM;
            end
          end
        end
      endcase
    end
  end

  assign din_ready  = w_din_ready;
  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: vector table, corner sequences and a randomized scoreboard run.
module tb_product_accumulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        v4 = 0, r4 = 1, v2 = 0, r2 = 1, v1 = 0, r1 = 1;
  logic [31:0] d4 = 0, d2 = 0, d1 = 0;
  logic        rdy4, rdy2, rdy1, ov4, ov2, ov1;
  logic [31:0] o4, o2, o1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  product_accumulator #(.COUNT(4)) dut4 (
    .clock(clock), .reset(reset), .din_valid(v4), .din_ready(rdy4), .din(d4),
    .dout_valid(ov4), .dout_ready(r4), .dout(o4));
  product_accumulator #(.COUNT(2)) dut2 (
    .clock(clock), .reset(reset), .din_valid(v2), .din_ready(rdy2), .din(d2),
    .dout_valid(ov2), .dout_ready(r2), .dout(o2));
  product_accumulator #(.COUNT(1)) dut1 (
    .clock(clock), .reset(reset), .din_valid(v1), .din_ready(rdy1), .din(d1),
    .dout_valid(ov1), .dout_ready(r1), .dout(o1));

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [31:0] d, input logic r,
                              input logic ev, input logic [31:0] ed, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed; t.er = er;
    tbl.push_back(t);
  endfunction

  // Group total as seen on the output: modulo 2^32, or clamped when saturating.
  function automatic logic [31:0] ref_reduce(input longint unsigned s);
`ifdef ACCUM_SAT_EN
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step4(input logic v, input logic [31:0] d, input logic r);
    @(negedge clock); v4 = v; d4 = d; r4 = r; #1;
  endtask
  task automatic step2(input logic v, input logic [31:0] d);
    @(negedge clock); v2 = v; d2 = d; r2 = 1'b1; #1;
  endtask
  task automatic step1(input logic v, input logic [31:0] d, input logic r);
    @(negedge clock); v1 = v; d1 = d; r1 = r; #1;
  endtask

  longint unsigned msum;
  int              mcnt;
  logic [31:0]     expq[$];
  logic            prev_stall;
  logic [31:0]     prev_dout;
  logic [31:0]     sat_ff, sat_hi;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef ACCUM_SAT_EN
    sat_ff = 32'hFFFF_FFFF; sat_hi = 32'hFFFF_FFFF;
`else
    sat_ff = 32'hFFFF_FFFE; sat_hi = 32'h0000_0000;
`endif
    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_vld4", ov4, 0);  chk("rst_dout4", o4, 0);  chk("rst_rdy4", rdy4, 1);
    chk("rst_vld2", ov2, 0);  chk("rst_rdy2", rdy2, 1);
    chk("rst_vld1", ov1, 0);  chk("rst_dout1", o1, 0);
    @(negedge clock); reset = 1'b0;

    // Streaming groups, sparse valid, output backpressure with same-cycle restart
    add(1, 1, 1, 0, 0, 1);   add(1, 2, 1, 0, 0, 1);  add(1, 3, 1, 0, 0, 1);  add(1, 4, 1, 0, 0, 1);
    add(1, 10, 1, 1, 10, 1); add(1, 20, 1, 0, 0, 1); add(1, 30, 1, 0, 0, 1); add(1, 40, 1, 0, 0, 1);
    add(0, 0, 1, 1, 100, 1); add(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) add((i % 2) == 0, 5, 1, i == 7, 20, 1);
    add(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 99, 0, 1, 4, 0);
    add(1, 7, 1, 1, 4, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 7, 1);   add(0, 0, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      step4(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_vld", i), ov4, tbl[i].ev);
      chk($sformatf("tbl%0d_rdy", i), rdy4, tbl[i].er);
      if (tbl[i].ev) chk($sformatf("tbl%0d_dout", i), o4, tbl[i].ed);
    end

    // Reset in the middle of a group discards the partial sum
    step4(1, 9, 1); step4(1, 9, 1);
    @(negedge clock); reset = 1'b1; v4 = 1; d4 = 7; #1;
    @(negedge clock); reset = 1'b0; v4 = 1; d4 = 5; #1;
    chk("rstmid_vld0", ov4, 0); chk("rstmid_dout0", o4, 0);
    for (int i = 1; i < 4; i++) begin
      step4(1, 5, 1);
      chk($sformatf("rstmid_vld%0d", i), ov4, 0);
      chk($sformatf("rstmid_dout%0d", i), o4, 0);
    end
    step4(0, 0, 1); chk("rstmid_tot_vld", ov4, 1); chk("rstmid_tot", o4, 20);
    step4(0, 0, 1); chk("rstmid_after", ov4, 0);

    // COUNT=2 overflow handling
    step2(1, 32'hFFFF_FFFF); chk("c2_vld_a", ov2, 0);
    step2(1, 32'hFFFF_FFFF);
    step2(1, 32'h8000_0000); chk("c2_vld_b", ov2, 1); chk("c2_ff", o2, sat_ff);
    step2(1, 32'h8000_0000); chk("c2_vld_c", ov2, 0);
    step2(1, 3);             chk("c2_vld_d", ov2, 1); chk("c2_hi", o2, sat_hi);
    step2(1, 4);             chk("c2_vld_e", ov2, 0);
    step2(0, 0);             chk("c2_vld_f", ov2, 1); chk("c2_small", o2, 7);
    step2(0, 0);             chk("c2_idle", ov2, 0);

    // COUNT=1 pass-through with continuous valid, then a stall
    step1(1, 3, 1); chk("c1_vld0", ov1, 0); chk("c1_rdy0", rdy1, 1);
    step1(1, 4, 1); chk("c1_vld1", ov1, 1); chk("c1_d1", o1, 3);
    step1(1, 5, 1); chk("c1_vld2", ov1, 1); chk("c1_d2", o1, 4);
    step1(1, 9, 0); chk("c1_vld3", ov1, 1); chk("c1_d3", o1, 5); chk("c1_rdy3", rdy1, 0);
    step1(0, 0, 1); chk("c1_vld4", ov1, 1); chk("c1_d4", o1, 5);
    step1(0, 0, 1); chk("c1_vld5", ov1, 0);

    // Randomized traffic against a group-sum scoreboard
    @(negedge clock); reset = 1'b1; v4 = 0; r4 = 1;
    @(negedge clock); reset = 1'b0;
    msum = 0; mcnt = 0; prev_stall = 1'b0; prev_dout = 0;
    for (int c = 0; c < 2500; c++) begin
      step4($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
            (c < 2400) ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (c >= 2400) v4 = 1'b0;
      #1;
      if (prev_stall) begin
        chk("rnd_hold_vld", ov4, 1);
        chk("rnd_hold_dout", o4, prev_dout);
      end
      if (ov4 && r4) begin
        if (expq.size() == 0) chk("rnd_unexpected_total", ov4, 0);
        else chk("rnd_total", o4, expq.pop_front());
      end
      if (v4 && rdy4) begin
        msum += longint'(d4);
        mcnt++;
        if (mcnt == 4) begin
          expq.push_back(ref_reduce(msum));
          msum = 0; mcnt = 0;
        end
      end
      prev_stall = ov4 && !r4;
      prev_dout  = o4;
    end
    chk("rnd_drained", 32'(expq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
